fetch_stage_pq: RTL

- Parametrised successor to the single-cycle fetch stage.
- Decouples PC generation from instruction memory through a request/grant port with variable latency, up to MAX_OUTSTANDING in-flight reads, and an in-order prefetch queue feeding decode.
- Redirects from Execute flush the queue and discard stale in-flight responses.
- Sits between the Execute redirect path and the IF/ID boundary.

---
 rtl/fetch_stage_pq_if.sv | 27 ++
 rtl/fetch_stage_pq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage_pq_if.sv
// Instruction-memory request/grant bus between the fetch stage (master)
// and instruction memory (slave). Responses return in request order.
interface fetch_stage_pq_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_pq.sv
// Fetch stage with a decoupled, variable-latency instruction-memory port,
// bounded in-flight reads and an in-order prefetch queue feeding decode.
// A redirect flushes the queue and marks every in-flight read as stale.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating perf counters
// (perf_fetched, perf_stall).
module fetch_stage_pq #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              QDEPTH          = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCSrcE,
  input  logic [XLEN-1:0]      PCTargetE,
  input  logic                 StallD,
  fetch_stage_pq_if.master     imem,
  output logic                 ValidF,
  output logic [31:0]          InstrF,
  output logic [XLEN-1:0]      PCF,
  output logic [XLEN-1:0]      PCPlus4F
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  localparam int PW = $clog2(QDEPTH);        // queue pointer width
  localparam int CW = $clog2(QDEPTH + 1);    // counter width, holds 0..QDEPTH
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Architectural state
  logic [XLEN-1:0] pc_reg;        // next address to request
  logic [XLEN-1:0] resp_pc_reg;   // PC belonging to the next accepted response
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;     // valid queue entries
  logic [CW-1:0]   outst_reg;     // granted but unanswered reads
  logic [CW-1:0]   drop_reg;      // in-flight reads still to be discarded

  // Queue storage, read combinationally at the head
  logic [31:0]     instr_mem [QDEPTH];
  logic [XLEN-1:0] pc_mem    [QDEPTH];

  logic [CW:0]     credit_sum;
  logic            grant;
  logic            rv;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_aligned;
  logic            unused_target_lsbs;

  assign unused_target_lsbs = ^PCTargetE[1:0];
  assign target_aligned     = {PCTargetE[XLEN-1:2], 2'b00};

  // Queue entries plus in-flight reads may never exceed the queue depth,
  // which is what makes an overflowing push impossible.
  assign credit_sum    = {1'b0, count_reg} + {1'b0, outst_reg};
  assign imem.imem_req = !rst && !PCSrcE
                         && (outst_reg < CW'(MAX_OUTSTANDING))
                         && (credit_sum < (CW+1)'(QDEPTH));
  assign imem.imem_addr = pc_reg;

  assign grant  = imem.imem_req && imem.imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rv     = imem.imem_rvalid && (outst_reg != '0);
  assign push   = rv && (drop_reg == '0) && !PCSrcE;
  assign ValidF = (count_reg != '0);
  assign pop    = ValidF && !StallD && !PCSrcE;

  assign InstrF   = ValidF ? instr_mem[rd_ptr_reg] : NOP;
  assign PCF      = ValidF ? pc_mem[rd_ptr_reg] : resp_pc_reg;
  assign PCPlus4F = PCF + XLEN'(4);

  // Control state: issue, response accounting, dequeue and redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      resp_pc_reg <= RESET_PC;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      outst_reg   <= '0;
      drop_reg    <= '0;
    end else begin
      outst_reg <= outst_reg + CW'(grant) - CW'(rv);
      if (PCSrcE) begin
        // Every read still in flight after this cycle is stale, including
        // ones already marked by an earlier redirect.
        count_reg   <= '0;
        rd_ptr_reg  <= wr_ptr_reg;
        drop_reg    <= outst_reg - CW'(rv);
        pc_reg      <= target_aligned;
        resp_pc_reg <= target_aligned;
      end else begin
        if (grant) begin
          pc_reg <= pc_reg + XLEN'(4);
        end
        if (push) begin
          wr_ptr_reg  <= wr_ptr_reg + PW'(1);
          resp_pc_reg <= resp_pc_reg + XLEN'(4);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        count_reg <= count_reg + CW'(push) - CW'(pop);
        if (rv && (drop_reg != '0)) begin
          drop_reg <= drop_reg - CW'(1);
        end
      end
    end
  end

  // Queue write port; storage needs no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem.imem_rdata;
      pc_mem[wr_ptr_reg]    <= resp_pc_reg;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  // Saturating counters of delivered instructions and stalled-valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
    end else begin
      if (pop && (perf_fetched_reg != 32'hFFFF_FFFF)) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (ValidF && StallD && (perf_stall_reg != 32'hFFFF_FFFF)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`endif

endmodule
